// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: sample-window encodings, idle line level and
// default prescale width.
package uart_rx_pkg;
  typedef enum logic [1:0] {
    SMP_1 = 2'b00,
    SMP_3 = 2'b01,
    SMP_5 = 2'b10,
    SMP_7 = 2'b11
  } smp_mode_e;

  localparam logic RX_IDLE       = 1'b1;
  localparam int   PRESCALE_W_DEF = 6;
endpackage

// File: rtl/majority_data_sampler_if.sv
// Sampler bus: the RX FSM/counter side (master) drives config, line and
// position; the sampler (slave) returns the bit decision and status.
interface majority_data_sampler_if #(
  parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W_DEF
);
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] edge_count;
  logic                  RX_IN;
  logic                  data_sampler_enable;
  logic [1:0]            sample_mode;
  logic                  sampled_data;
  logic                  sampled_data_valid;
  logic                  sample_noise;
  logic                  config_err;

  modport master (
    output prescale, edge_count, RX_IN, data_sampler_enable, sample_mode,
    input  sampled_data, sampled_data_valid, sample_noise, config_err
  );

  modport slave (
    input  prescale, edge_count, RX_IN, data_sampler_enable, sample_mode,
    output sampled_data, sampled_data_valid, sample_noise, config_err
  );
endinterface

// File: rtl/rx_sync.sv
// N-stage synchroniser that resets to the idle line level; STAGES=0 is a
// straight wire for inputs that are already synchronous.
module rx_sync import uart_rx_pkg::*; #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  generate
    if (STAGES == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_ff
      logic [STAGES-1:0] r_sync;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync <= {STAGES{RX_IDLE}};
        end else begin
          r_sync[0] <= i_d;
          for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end
      assign o_q = r_sync[STAGES-1];
    end
  endgenerate
endmodule

// File: rtl/majority_data_sampler.sv
// Oversampling majority sampler: takes 1/3/5/7 samples centred in the bit,
// emits the majority with a one-cycle valid and a non-unanimous noise flag.
module majority_data_sampler import uart_rx_pkg::*; #(
  parameter int PRESCALE_W  = PRESCALE_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic                    clk_based_on_prescale,
  input logic                    rst,
  majority_data_sampler_if.slave bus
);
  localparam int W = PRESCALE_W + 1;

  logic            w_rx;
  smp_mode_e       w_mode;
  logic [W-1:0]    w_ps, w_ec, w_half, w_center, w_first, w_last;
  logic            w_legal, w_in_win, w_at_first, w_at_last, w_take;
  logic [2:0]      w_tot;
  logic            w_zeros;

  logic [2:0]      r_ones;
  logic            r_zeros;
  logic            r_data, r_valid, r_noise, r_cfg_err;

  rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk_based_on_prescale),
    .rst (rst),
    .i_d (bus.RX_IN),
    .o_q (w_rx)
  );

  // One extra bit of headroom so center+half never wraps.
  assign w_mode   = smp_mode_e'(bus.sample_mode);
  assign w_ps     = {1'b0, bus.prescale};
  assign w_ec     = {1'b0, bus.edge_count};
  assign w_half   = W'(w_mode);
  assign w_center = w_ps >> 1;
  assign w_first  = w_center - w_half;
  assign w_last   = w_center + w_half;

  // center > half is first >= 1 without relying on the subtraction.
  assign w_legal    = ~w_ps[0] && (w_ps >= W'(4)) && (w_center > w_half) &&
                      (w_last <= w_ps - W'(1));
  assign w_in_win   = (w_ec >= w_first) && (w_ec <= w_last);
  assign w_at_first = (w_ec == w_first);
  assign w_at_last  = (w_ec == w_last);
  assign w_take     = bus.data_sampler_enable && w_legal && w_in_win;

  // Running totals including the current sample; a window start reloads.
  assign w_tot   = (w_at_first ? 3'd0 : r_ones) + {2'b00, w_rx};
  assign w_zeros = (w_at_first ? 1'b0 : r_zeros) | ~w_rx;

  always_ff @(posedge clk_based_on_prescale or posedge rst) begin
    if (rst) begin
      r_ones    <= '0;
      r_zeros   <= 1'b0;
      r_data    <= RX_IDLE;
      r_valid   <= 1'b0;
      r_noise   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= ~w_legal;
      r_valid   <= 1'b0;
      if (!bus.data_sampler_enable) begin
        r_ones  <= '0;
        r_zeros <= 1'b0;
      end else if (w_take) begin
        r_ones  <= w_tot;
        r_zeros <= w_zeros;
        if (w_at_last) begin
          r_data  <= (w_tot > {1'b0, bus.sample_mode});
          r_noise <= (w_tot != 3'd0) && w_zeros;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.sampled_data       = r_data;
  assign bus.sampled_data_valid = r_valid;
  assign bus.sample_noise       = r_noise;
  assign bus.config_err         = r_cfg_err;
endmodule

// File: tb/tb_majority_data_sampler.sv
// Directed bench: table of whole-bit vectors on a bypass-sync instance, plus
// hand sequences for enable abort, async reset and synchroniser latency.
module tb_majority_data_sampler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  majority_data_sampler_if #(.PRESCALE_W(6)) b0 ();
  majority_data_sampler_if #(.PRESCALE_W(6)) b2 ();

  assign b2.prescale            = b0.prescale;
  assign b2.edge_count          = b0.edge_count;
  assign b2.RX_IN               = b0.RX_IN;
  assign b2.data_sampler_enable = b0.data_sampler_enable;
  assign b2.sample_mode         = b0.sample_mode;

  majority_data_sampler #(.PRESCALE_W(6), .SYNC_STAGES(0)) u_dut0 (
    .clk_based_on_prescale (clk),
    .rst                   (rst),
    .bus                   (b0)
  );
  majority_data_sampler #(.PRESCALE_W(6), .SYNC_STAGES(2)) u_dut2 (
    .clk_based_on_prescale (clk),
    .rst                   (rst),
    .bus                   (b2)
  );

  typedef struct {
    logic [5:0]  ps;
    logic [1:0]  mode;
    logic [63:0] mask;
    int          vld;
    logic        d;
    logic        n;
    logic        cfg;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] ps, input logic [1:0] mode, input int e,
                       input logic rx, input logic en);
    b0.prescale            = ps;
    b0.sample_mode         = mode;
    b0.edge_count          = 6'(e);
    b0.RX_IN               = rx;
    b0.data_sampler_enable = en;
  endtask

  task automatic run_bit(input logic [5:0] ps, input logic [1:0] mode, input logic [63:0] mask,
                         input bit sel2, output int nv, output logic d, output logic n);
    nv = 0; d = 1'b0; n = 1'b0;
    for (int e = 0; e < int'(ps); e++) begin
      drive(ps, mode, e, mask[e], 1'b1);
      @(posedge clk); #1;
      if (sel2 ? b2.sampled_data_valid : b0.sampled_data_valid) begin
        nv++;
        d = sel2 ? b2.sampled_data : b0.sampled_data;
        n = sel2 ? b2.sample_noise : b0.sample_noise;
      end
    end
  endtask

  vec_t vt[13];

  initial begin
    int   nv;
    logic d, n;

    vt[0]  = '{6'd8,  2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{6'd16, 2'd2, 64'h100,                 1, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{6'd16, 2'd2, 64'h380,                 1, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{6'd10, 2'd3, 64'h203,                 1, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{6'd10, 2'd3, 64'h38E,                 1, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{6'd6,  2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{6'd9,  2'd1, 64'h0,                   0, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{6'd4,  2'd1, 64'hA,                   1, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{6'd4,  2'd2, 64'h0,                   0, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{6'd8,  2'd0, 64'h10,                  1, 1'b1, 1'b0, 1'b0};
    vt[10] = '{6'd8,  2'd0, 64'hEF,                  1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{6'd2,  2'd0, 64'h0,                   0, 1'b0, 1'b0, 1'b1};
    vt[12] = '{6'd32, 2'd1, 64'h0,                   1, 1'b0, 1'b0, 1'b0};

    drive(6'd8, 2'd1, 0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #2;
    chk("rst_data",  32'(b0.sampled_data),       32'd1);
    chk("rst_valid", 32'(b0.sampled_data_valid), 32'd0);
    chk("rst_noise", 32'(b0.sample_noise),       32'd0);
    chk("rst_cfg",   32'(b0.config_err),         32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_bit(vt[i].ps, vt[i].mode, vt[i].mask, 1'b0, nv, d, n);
      chk($sformatf("v%0d_vld", i), 32'(nv), 32'(vt[i].vld));
      chk($sformatf("v%0d_cfg", i), 32'(b0.config_err), 32'(vt[i].cfg));
      if (vt[i].vld != 0) begin
        chk($sformatf("v%0d_data", i),  32'(d), 32'(vt[i].d));
        chk($sformatf("v%0d_noise", i), 32'(n), 32'(vt[i].n));
      end
    end

    // Enable drops mid-window: no decision for that bit.
    nv = 0;
    for (int e = 0; e < 32; e++) begin
      drive(6'd32, 2'd1, e, 1'b0, (e < 16));
      @(posedge clk); #1;
      if (b0.sampled_data_valid) nv++;
    end
    chk("abort_vld", 32'(nv), 32'd0);
    run_bit(6'd32, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, nv, d, n);
    chk("reen_vld",   32'(nv), 32'd1);
    chk("reen_data",  32'(d),  32'd1);
    chk("reen_noise", 32'(n),  32'd0);

    // Async reset at edge_count 9 of a 16x, 3-sample bit.
    run_bit(6'd16, 2'd1, 64'h100, 1'b0, nv, d, n);
    chk("prerst_data",  32'(d), 32'd0);
    chk("prerst_noise", 32'(n), 32'd1);
    nv = 0;
    for (int e = 0; e < 9; e++) begin
      drive(6'd16, 2'd1, e, 1'b1, 1'b1);
      @(posedge clk); #1;
      if (b0.sampled_data_valid) nv++;
    end
    drive(6'd16, 2'd1, 9, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_data",  32'(b0.sampled_data),       32'd1);
    chk("arst_valid", 32'(b0.sampled_data_valid), 32'd0);
    chk("arst_noise", 32'(b0.sample_noise),       32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int e = 10; e < 16; e++) begin
      drive(6'd16, 2'd1, e, 1'b1, 1'b1);
      @(posedge clk); #1;
      if (b0.sampled_data_valid) nv++;
    end
    chk("arst_novld", 32'(nv), 32'd0);
    run_bit(6'd16, 2'd1, 64'h280, 1'b0, nv, d, n);
    chk("postrst_vld",   32'(nv), 32'd1);
    chk("postrst_data",  32'(d),  32'd1);
    chk("postrst_noise", 32'(n),  32'd1);

    // Two-flop synchroniser: step at edge 2 seen at edge 4, step at 3 not.
    for (int e = 0; e < 3; e++) begin
      drive(6'd8, 2'd0, 0, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    run_bit(6'd8, 2'd0, 64'h3, 1'b1, nv, d, n);
    chk("sync2_vld",  32'(nv), 32'd1);
    chk("sync2_data", 32'(d),  32'd0);
    run_bit(6'd8, 2'd0, 64'h7, 1'b1, nv, d, n);
    chk("sync3_vld",  32'(nv), 32'd1);
    chk("sync3_data", 32'(d),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
